// File: rtl/exception_controller_pkg.sv
// Shared definitions for the exception controller and the coprocessor register file.
// Holds the cause codes, FSM state encoding and default handler entry address.
package exception_controller_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_OVERFLOW = 2'd1,
        CAUSE_IO       = 2'd2,
        CAUSE_DOUBLE   = 2'd3
    } cause_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_SAVE    = 3'd2,
        ST_VECTOR  = 3'd3,
        ST_HANDLER = 3'd4,
        ST_RETURN  = 3'd5,
        ST_FATAL   = 3'd6
    } state_e;

    localparam logic [15:0] HANDLER_ADDR_DEFAULT = 16'h0100;

endpackage

// File: rtl/exception_priority.sv
// Trap selection for a retiring instruction: overflow beats a pending I/O request.
// EPC is the faulting pc for overflow, or the following instruction for I/O.
module exception_priority
    import exception_controller_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int INST_STEP = 2
) (
    input  logic              i_inst_valid,
    input  logic              i_overflow,
    input  logic              i_io_request,
    input  logic              i_interrupts_enabled,
    input  logic [DATA_W-1:0] i_pc,
    output logic              o_take,
    output cause_e            o_cause,
    output logic [DATA_W-1:0] o_epc
);

    logic w_ovf;
    logic w_io;

    assign w_ovf = i_inst_valid & i_overflow;
    assign w_io  = i_inst_valid & i_io_request & i_interrupts_enabled;

    always_comb begin
        o_take  = w_ovf | w_io;
        o_cause = CAUSE_NONE;
        o_epc   = i_pc;
        if (w_ovf) begin
            o_cause = CAUSE_OVERFLOW;
        end else if (w_io) begin
            // Interrupted instruction has completed, so resume after it; wraps at 2^DATA_W.
            o_cause = CAUSE_IO;
            o_epc   = i_pc + DATA_W'(INST_STEP);
        end
    end

endmodule

// File: rtl/exception_controller.sv
// Exception sequencing FSM: captures cause/EPC, saves context, vectors to the handler
// and restores on eret. A fault inside the handler is a double fault and locks up.
//
// state   | meaning
// IDLE    | user mode, watching for traps
// CAPTURE | write cause and EPC to the coprocessor
// SAVE    | copy mary/shelley to backups
// VECTOR  | redirect to handler, ack I/O, enter kernel mode
// HANDLER | kernel code running, waits for eret
// RETURN  | restore context, redirect to EPC
// FATAL   | double fault, stalled until reset
module exception_controller
    import exception_controller_pkg::*;
#(
    parameter int                DATA_W       = 16,
    parameter logic [DATA_W-1:0] HANDLER_ADDR = DATA_W'(HANDLER_ADDR_DEFAULT),
    parameter int                INST_STEP    = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              overflow,
    input  logic              io_request,
    input  logic              interrupts_enabled,
    input  logic              inst_valid,
    input  logic              eret,
    input  logic [DATA_W-1:0] pc,
    output logic              cause_write,
    output logic [1:0]        cause_code,
    output logic              epc_write,
    output logic [DATA_W-1:0] epc_value,
    output logic              save_write,
    output logic              restore,
    output logic              pc_redirect,
    output logic [DATA_W-1:0] redirect_addr,
    output logic              stall,
    output logic              io_ack,
    output logic              mode
);

    state_e            r_state;
    state_e            w_next;
    cause_e            r_cause;
    logic [DATA_W-1:0] r_epc;
    logic              r_io_trap;
    logic              r_fatal_entry;

    logic              w_take;
    cause_e            w_cause;
    logic [DATA_W-1:0] w_epc;
    logic              w_retire_ovf;
    logic              w_retire_eret;

    assign w_retire_ovf  = inst_valid & overflow;
    assign w_retire_eret = inst_valid & eret;

    exception_priority #(
        .DATA_W    (DATA_W),
        .INST_STEP (INST_STEP)
    ) u_priority (
        .i_inst_valid         (inst_valid),
        .i_overflow           (overflow),
        .i_io_request         (io_request),
        .i_interrupts_enabled (interrupts_enabled),
        .i_pc                 (pc),
        .o_take               (w_take),
        .o_cause              (w_cause),
        .o_epc                (w_epc)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_cause       <= CAUSE_NONE;
            r_epc         <= '0;
            r_io_trap     <= 1'b0;
            r_fatal_entry <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_fatal_entry <= 1'b0;
            if (r_state == ST_IDLE && w_take) begin
                r_cause   <= w_cause;
                r_epc     <= w_epc;
                r_io_trap <= (w_cause == CAUSE_IO);
            end
            // Double fault keeps the original EPC so the coprocessor still shows the first trap site.
            if (r_state == ST_HANDLER && w_retire_ovf) begin
                r_cause       <= CAUSE_DOUBLE;
                r_fatal_entry <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        cause_write   = 1'b0;
        epc_write     = 1'b0;
        save_write    = 1'b0;
        restore       = 1'b0;
        pc_redirect   = 1'b0;
        redirect_addr = '0;
        stall         = 1'b0;
        io_ack        = 1'b0;
        mode          = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_take) w_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                cause_write = 1'b1;
                epc_write   = 1'b1;
                stall       = 1'b1;
                w_next      = ST_SAVE;
            end
            ST_SAVE: begin
                save_write = 1'b1;
                stall      = 1'b1;
                w_next     = ST_VECTOR;
            end
            ST_VECTOR: begin
                pc_redirect   = 1'b1;
                redirect_addr = HANDLER_ADDR;
                io_ack        = r_io_trap;
                stall         = 1'b1;
                mode          = 1'b1;
                w_next        = ST_HANDLER;
            end
            ST_HANDLER: begin
                mode = 1'b1;
                if (w_retire_ovf)       w_next = ST_FATAL;
                else if (w_retire_eret) w_next = ST_RETURN;
            end
            ST_RETURN: begin
                restore       = 1'b1;
                pc_redirect   = 1'b1;
                redirect_addr = r_epc;
                stall         = 1'b1;
                mode          = 1'b1;
                w_next        = ST_IDLE;
            end
            ST_FATAL: begin
                cause_write = r_fatal_entry;
                stall       = 1'b1;
                mode        = 1'b1;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign cause_code = r_cause;
    assign epc_value  = r_epc;

endmodule

// File: tb/tb_exception_controller.sv
// Scoreboard bench for exception_controller: a trap-level reference model predicts every
// strobe cycle; a negedge monitor compares what the DUT presents against the queue.
module tb_exception_controller;

    logic        clock;
    logic        reset_n;
    logic        overflow;
    logic        io_request;
    logic        interrupts_enabled;
    logic        inst_valid;
    logic        eret;
    logic [15:0] pc;
    logic        cause_write;
    logic [1:0]  cause_code;
    logic        epc_write;
    logic [15:0] epc_value;
    logic        save_write;
    logic        restore;
    logic        pc_redirect;
    logic [15:0] redirect_addr;
    logic        stall;
    logic        io_ack;
    logic        mode;

    exception_controller dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .overflow           (overflow),
        .io_request         (io_request),
        .interrupts_enabled (interrupts_enabled),
        .inst_valid         (inst_valid),
        .eret               (eret),
        .pc                 (pc),
        .cause_write        (cause_write),
        .cause_code         (cause_code),
        .epc_write          (epc_write),
        .epc_value          (epc_value),
        .save_write         (save_write),
        .restore            (restore),
        .pc_redirect        (pc_redirect),
        .redirect_addr      (redirect_addr),
        .stall              (stall),
        .io_ack             (io_ack),
        .mode               (mode)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic        cw;
        logic [1:0]  code;
        logic        ew;
        logic [15:0] epc;
        logic        sw;
        logic        rs;
        logic        rd;
        logic [15:0] raddr;
        logic        ack;
        logic        md;
        logic        st;
    } snap_t;

    typedef struct {
        int    cyc;
        snap_t s;
    } exp_t;

    localparam int CTX_USER   = 0;
    localparam int CTX_KERNEL = 1;
    localparam int CTX_FATAL  = 2;

    exp_t        q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    int          m_ctx = CTX_USER;
    int          m_ready = 0;
    logic [1:0]  m_code = 2'd0;
    logic [15:0] m_epc = 16'h0;
    int          io_ack_cyc = -1;
    logic        io_line = 1'b0;
    logic        ie_line = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endfunction

    function automatic snap_t observe();
        snap_t s;
        s.cw = cause_write;  s.code = cause_code; s.ew = epc_write; s.epc = epc_value;
        s.sw = save_write;   s.rs = restore;      s.rd = pc_redirect; s.raddr = redirect_addr;
        s.ack = io_ack;      s.md = mode;         s.st = stall;
        return s;
    endfunction

    function automatic snap_t mk(logic cw, logic ew, logic sw, logic rs, logic rd,
                                 logic [15:0] ra, logic ack, logic md, logic st);
        snap_t s;
        s.cw = cw;  s.code = m_code; s.ew = ew; s.epc = m_epc;
        s.sw = sw;  s.rs = rs;       s.rd = rd; s.raddr = ra;
        s.ack = ack; s.md = md;      s.st = st;
        return s;
    endfunction

    function automatic void push(int c, snap_t s);
        exp_t e;
        e.cyc = c;
        e.s   = s;
        q.push_back(e);
    endfunction

    // A trap costs three visible cycles: capture, save, vector; the handler runs from the fourth.
    function automatic void trap(int c, logic [1:0] code, logic [15:0] epc, logic is_io);
        m_code = code;
        m_epc  = epc;
        push(c + 1, mk(1, 1, 0, 0, 0, 16'h0000, 0, 0, 1));
        push(c + 2, mk(0, 0, 1, 0, 0, 16'h0000, 0, 0, 1));
        push(c + 3, mk(0, 0, 0, 0, 1, 16'h0100, is_io, 1, 1));
        m_ready = c + 4;
        m_ctx   = CTX_KERNEL;
        if (is_io) io_ack_cyc = c + 3;
    endfunction

    task automatic step(input logic iv, input logic ov, input logic io, input logic ie,
                        input logic er, input logic [15:0] p);
        int c;
        @(posedge clock);
        #1;
        inst_valid = iv; overflow = ov; io_request = io;
        interrupts_enabled = ie; eret = er; pc = p;
        c = cyc;
        if (c >= m_ready) begin
            if (m_ctx == CTX_USER) begin
                if (iv && ov)            trap(c, 2'd1, p, 1'b0);
                else if (iv && io && ie) trap(c, 2'd2, 16'(p + 16'd2), 1'b1);
            end else if (m_ctx == CTX_KERNEL && iv) begin
                if (ov) begin
                    m_code = 2'd3;
                    push(c + 1, mk(1, 0, 0, 0, 0, 16'h0000, 0, 1, 1));
                    m_ctx = CTX_FATAL;
                end else if (er) begin
                    push(c + 1, mk(0, 0, 0, 1, 1, m_epc, 0, 1, 1));
                    m_ready = c + 2;
                    m_ctx   = CTX_USER;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, io_line, ie_line, 1'b0, 16'h0000);
    endtask

    task automatic model_reset();
        q.delete();
        m_ctx = CTX_USER; m_ready = 0; m_code = 2'd0; m_epc = 16'h0;
        io_ack_cyc = -1; io_line = 1'b0; ie_line = 1'b0;
        inst_valid = 0; overflow = 0; io_request = 0; interrupts_enabled = 0; eret = 0; pc = 16'h0;
    endtask

    task automatic do_reset(input string nm);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk(nm, 64'(observe()), 64'h0);
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    always @(negedge clock) begin
        snap_t o;
        exp_t  e;
        if (reset_n) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_strobe cyc=%0d actual=none required=%h", q[0].cyc, q[0].s);
                q.delete(0);
            end
            o = observe();
            if (o.cw | o.ew | o.sw | o.rs | o.rd | o.ack) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_strobe cyc=%0d actual=%h required=no strobe", cyc, o);
                end else begin
                    e = q.pop_front();
                    chk("strobe_cycle", 64'(cyc), 64'(e.cyc));
                    chk("strobe_snapshot", 64'(o), 64'(e.s));
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        model_reset();
        #3;
        chk("reset_outputs", 64'(observe()), 64'h0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Overflow at 0x0040, then eret back.
        step(1, 1, 0, 0, 0, 16'h0040);
        idle(4);
        chk("handler_mode", 64'(mode), 64'd1);
        chk("handler_stall", 64'(stall), 64'd0);
        step(1, 0, 0, 0, 1, 16'h0104);
        idle(2);
        chk("user_mode_after_return", 64'(mode), 64'd0);
        chk("user_stall_after_return", 64'(stall), 64'd0);

        // eret in user mode is ignored.
        step(1, 0, 0, 0, 1, 16'h0060);
        idle(2);

        // I/O trap at 0x0040 with interrupts enabled.
        io_line = 1; ie_line = 1;
        step(1, 0, io_line, ie_line, 0, 16'h0040);
        idle(3);
        io_line = 0;
        idle(1);
        step(1, 0, 0, 1, 1, 16'h0108);
        idle(2);

        // I/O request with interrupts disabled: nothing happens.
        io_line = 1; ie_line = 0;
        repeat (5) step(1, 0, io_line, ie_line, 0, 16'h0040);
        chk("io_disabled_stall", 64'(stall), 64'd0);
        chk("io_disabled_mode", 64'(mode), 64'd0);
        io_line = 0;
        idle(1);

        // Overflow and I/O together: overflow first, I/O taken after return.
        io_line = 1; ie_line = 1;
        step(1, 1, io_line, ie_line, 0, 16'h0040);
        idle(4);
        step(1, 0, io_line, ie_line, 1, 16'h0110);
        idle(1);
        step(1, 0, io_line, ie_line, 0, 16'h0050);
        idle(3);
        io_line = 0;
        idle(1);
        step(1, 0, 0, 1, 1, 16'h0112);
        idle(2);

        // I/O trap at the top of the address space wraps EPC.
        io_line = 1; ie_line = 1;
        step(1, 0, io_line, ie_line, 0, 16'hFFFE);
        idle(3);
        io_line = 0;
        idle(1);
        step(1, 0, 0, 1, 1, 16'h0114);
        idle(2);

        // Randomized traffic, no double faults.
        for (int k = 0; k < 600; k++) begin
            int          nxt;
            logic        iv;
            logic        ov;
            logic        er;
            logic [15:0] p;
            nxt = cyc + 1;
            if (io_ack_cyc >= 0 && nxt > io_ack_cyc) begin
                io_line    = 1'b0;
                io_ack_cyc = -1;
            end else if (!io_line && $urandom_range(0, 5) == 0) begin
                io_line = 1'b1;
            end
            ie_line = ($urandom_range(0, 1) == 1);
            p = 16'($urandom) & 16'hFFFE;
            if ($urandom_range(0, 15) == 0) p = 16'hFFFE;
            iv = 0; ov = 0; er = 0;
            if (nxt >= m_ready) begin
                iv = ($urandom_range(0, 3) != 0);
                er = ($urandom_range(0, 3) == 0);
                if (m_ctx == CTX_USER) ov = ($urandom_range(0, 7) == 0);
            end
            step(iv, ov, io_line, ie_line, er, p);
        end
        io_line = 0;
        idle(5);
        chk("random_queue_drained", 64'(q.size()), 64'd0);

        // Double fault: overflow inside the handler locks into FATAL until reset.
        do_reset("reset_before_fatal");
        step(1, 1, 0, 0, 0, 16'h0200);
        idle(4);
        step(1, 1, 0, 0, 0, 16'h0102);
        for (int k = 0; k < 6; k++) begin
            step(1, 0, 0, 0, 1, 16'h0104);
            chk("fatal_stall_held", 64'(stall), 64'd1);
        end
        chk("fatal_cause_held", 64'(cause_code), 64'd3);
        do_reset("reset_from_fatal");
        idle(1);
        chk("stall_after_fatal_reset", 64'(stall), 64'd0);
        chk("mode_after_fatal_reset", 64'(mode), 64'd0);

        // Reset asserted mid-sequence during SAVE.
        step(1, 1, 0, 0, 0, 16'h0300);
        idle(1);
        @(posedge clock);
        #1;
        chk("save_before_reset", 64'(save_write), 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("reset_in_save_outputs", 64'(observe()), 64'h0);
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        idle(2);
        chk("mode_after_save_reset", 64'(mode), 64'd0);
        chk("stall_after_save_reset", 64'(stall), 64'd0);
        step(1, 0, 1, 1, 0, 16'h0400);
        io_line = 1; ie_line = 1;
        idle(3);
        io_line = 0;
        idle(3);
        chk("final_queue_drained", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
